// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the first-word-fall-through FIFO.
package fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } ostate_t;

    // One extra bit so the level can represent a completely full RAM.
    function automatic int level_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/SdpRamRf.sv
// SdpRamRf: simple dual-port register-file RAM, one write port, one registered read port.
module SdpRamRf #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_out_stage.sv
// fifo_out_stage: 2-entry FWFT output buffer; entry 0 is always the head.
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data,
    input  logic          arrive,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [1:0]    count
);

    ostate_t       state;
    logic [DW-1:0] e0, e1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            unique case (state)
                S_EMPTY: if (arrive) begin
                    e0    <= data;
                    state <= S_ONE;
                end
                S_ONE: begin
                    if (arrive && !pop) begin
                        e1    <= data;
                        state <= S_TWO;
                    end else if (arrive && pop) begin
                        e0 <= data;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: if (pop) begin
                    e0    <= e1;
                    state <= S_ONE;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // The prefetch rule never lets a word land while both entries are held.
    a_no_overfill: assert property (@(posedge clk) disable iff (rst) !(state == S_TWO && arrive));

    assign valid = state != S_EMPTY;
    assign head  = valid ? e0 : '0;
    assign count = state == S_TWO ? 2'd2 : state == S_ONE ? 2'd1 : 2'd0;

endmodule

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO over SdpRamRf with a 2-entry output stage.
// FIFO_ERR_STICKY_EN makes overflow/underflow sticky until rst; otherwise they are 1-cycle pulses.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int WORDS = 1024,
    parameter int AF_TH = WORDS - 4,
    parameter int AE_TH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          write,
    output logic          full,
    output logic          almost_full,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          read,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          underflow
);

    localparam int LW = level_width(AW);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] ram_cnt;
    logic          inflight;
    logic [DW-1:0] rdata;
    logic [1:0]    cnt;
    logic          push, pop, issue;

    assign push  = write && !full;
    assign pop   = read && dout_valid;
    // A same-cycle pop frees an output entry, keeping one word per cycle flowing.
    assign issue = (ram_cnt != '0) && (3'(cnt) + 3'(inflight) - 3'(pop) < 3'd2);

    assign full         = level == LW'(WORDS);
    assign empty        = level == '0;
    assign almost_full  = (AF_TH <= 0) || (level >= LW'(AF_TH));
    assign almost_empty = (AE_TH >= 0) && (level <= LW'(AE_TH));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            inflight  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(push);
            rd_ptr   <= rd_ptr + AW'(issue);
            ram_cnt  <= ram_cnt + LW'(push) - LW'(issue);
            level    <= level + LW'(push) - LW'(pop);
            inflight <= issue;
`ifdef FIFO_ERR_STICKY_EN
            overflow  <= overflow | (write && full);
            underflow <= underflow | (read && !dout_valid);
`else
            overflow  <= write && full;
            underflow <= read && !dout_valid;
`endif
        end
    end

    a_level_bound: assert property (@(posedge clk) disable iff (rst) level <= LW'(WORDS));

    SdpRamRf #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    fifo_out_stage #(.DW(DW)) u_out (
        .clk    (clk),
        .rst    (rst),
        .data   (rdata),
        .arrive (inflight),
        .pop    (pop),
        .head   (dout),
        .valid  (dout_valid),
        .count  (cnt)
    );

endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: directed and random checks of fifo_fwft against a queue-based reference model.
module tb_fifo_fwft;

    logic       clk = 1'b0, rst = 1'b1, write = 1'b0, read = 1'b0;
    logic [7:0] din = '0;
    logic       full, almost_full, dout_valid, empty, almost_empty, overflow, underflow;
    logic [7:0] dout;
    logic [4:0] level;

    typedef struct {
        logic [7:0] d;
        int         t;
    } ent_t;

    ent_t q[$];
    int   checks = 0, fails = 0, cyc = 0;
    logic ov_m = 1'b0, un_m = 1'b0;

    always #5 clk = ~clk;

    fifo_fwft #(.DW(8), .AW(4), .WORDS(16), .AF_TH(14), .AE_TH(2)) dut (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
        .almost_full(almost_full), .dout(dout), .dout_valid(dout_valid),
        .read(read), .empty(empty), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    // A word becomes visible at the head two edges after the edge that accepted it.
    function automatic logic model_valid();
        return q.size() > 0 && cyc >= q[0].t + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic       v;
        logic [7:0] hd;
        v  = model_valid();
        hd = v ? q[0].d : 8'h00;
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == 16));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
        chk("dout_valid", 32'(dout_valid), 32'(v));
        chk("dout", 32'(dout), 32'(hd));
        chk("overflow", 32'(overflow), 32'(ov_m));
        chk("underflow", 32'(underflow), 32'(un_m));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        logic f, v;
        f     = q.size() == 16;
        v     = model_valid();
        write = w;
        din   = d;
        read  = r;
        @(posedge clk);
        cyc++;
        if (r && v) void'(q.pop_front());
        if (w && !f) q.push_back('{d: d, t: cyc});
`ifdef FIFO_ERR_STICKY_EN
        ov_m = ov_m | (w && f);
        un_m = un_m | (r && !v);
`else
        ov_m = w && f;
        un_m = r && !v;
`endif
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        @(posedge clk);
        cyc++;
        q.delete();
        ov_m = 1'b0;
        un_m = 1'b0;
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        do_reset();
        // Latency into an empty FIFO.
        step(1'b1, 8'h11, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        // Fill to full, then one rejected push.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        // Drain back-to-back, then one rejected pop and an idle stretch.
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        repeat (10) step(1'b0, 8'h00, 1'b0);
        do_reset();
        // Streaming at level 5 wraps both pointers.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        // Reset with level 9 and a prefetch in flight.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom), 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        do_reset();
        step(1'b1, 8'hA5, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        // Random traffic, including over/underflow attempts.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50));
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 99) < 85), 8'($urandom), 1'($urandom_range(0, 99) < 30));
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 99) < 20), 8'($urandom), 1'($urandom_range(0, 99) < 80));
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
